uart_rx: RTL and testbench

Serial receiver paired with the UART transmitter: it consumes the transmitter's serial `data_out` line and recovers the parallel byte plus error flags. Frame configuration (baud rate, parity, stop bits, data length) uses the same control encoding as the transmitter, so one configuration bus drives both ends of a loopback link. Internally it contains a 16x oversampling tick generator, a 2-FF input synchronizer and a frame-decoding FSM.

---
 rtl/uart_rx_if.sv | 33 +++
 rtl/uart_rx.sv | 198 +++++++++++++++++++
 tb/tb_uart_rx.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// uart_rx_if: groups the serial line, frame configuration and receive
// results of uart_rx into one bundle.
//   data_in      serial line in (idles high, asynchronous)
//   baud_rate    00=2400 01=4800 10=9600 11=19200
//   parity_type  00=none 01=odd 10=even 11=none
//   stop_bits    0=one stop bit, 1=two
//   data_length  0=7 data bits, 1=8 data bits
//   data_out     received word (bit 7 is 0 in 7-bit mode)
//   rx_done      one-cycle frame-complete pulse
//   rx_active    frame reception in progress
//   parity_error / stop_error  flags for the last frame
interface uart_rx_if;
  logic       data_in;
  logic [1:0] baud_rate;
  logic [1:0] parity_type;
  logic       stop_bits;
  logic       data_length;
  logic [7:0] data_out;
  logic       rx_done;
  logic       rx_active;
  logic       parity_error;
  logic       stop_error;

  modport master (
    output data_in, baud_rate, parity_type, stop_bits, data_length,
    input  data_out, rx_done, rx_active, parity_error, stop_error
  );

  modport slave (
    input  data_in, baud_rate, parity_type, stop_bits, data_length,
    output data_out, rx_done, rx_active, parity_error, stop_error
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: UART serial receiver with 16x oversampling, 2-FF input
// synchronizer and frame-decoding FSM. Frame format is latched when a
// start bit is detected.
//   clock  system clock, rising edge
//   rst    synchronous reset, active-low
//   bus    uart_rx_if slave: serial line + config in, word + flags out
module uart_rx #(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input logic      clock,
  input logic      rst,
  uart_rx_if.slave bus
);

  localparam int unsigned DIV_2400  = CLK_FREQ / (16 * 2400);
  localparam int unsigned DIV_4800  = CLK_FREQ / (16 * 4800);
  localparam int unsigned DIV_9600  = CLK_FREQ / (16 * 9600);
  localparam int unsigned DIV_19200 = CLK_FREQ / (16 * 19200);
  localparam int unsigned CW        = $clog2(DIV_2400 + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic            sync1_q, sync1_d, sync2_q, sync2_d;
  logic            armed_q, armed_d;
  logic [CW-1:0]   div_cnt_q, div_cnt_d;
  logic [3:0]      tcnt_q, tcnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [1:0]      baud_q, baud_d;
  logic [1:0]      par_q, par_d;
  logic            stop2_q, stop2_d;
  logic            len8_q, len8_d;
  logic            stop_cnt_q, stop_cnt_d;
  logic            pend_perr_q, pend_perr_d;
  logic            pend_serr_q, pend_serr_d;
  logic [7:0]      data_out_q, data_out_d;
  logic            perr_q, perr_d;
  logic            serr_q, serr_d;

  logic            rxd;
  logic            tick;
  logic            par_en;
  logic [CW-1:0]   div_sel;
  logic [7:0]      word;

  always_comb begin
    rxd = sync2_q;
    unique case (baud_q)
      2'b00:   div_sel = CW'(DIV_2400);
      2'b01:   div_sel = CW'(DIV_4800);
      2'b10:   div_sel = CW'(DIV_9600);
      default: div_sel = CW'(DIV_19200);
    endcase
    tick   = (state_q != S_IDLE) && (div_cnt_q == div_sel - CW'(1));
    par_en = (par_q == 2'b01) || (par_q == 2'b10);
    word   = len8_q ? shift_q : {1'b0, shift_q[7:1]};

    state_d     = state_q;
    sync1_d     = bus.data_in;
    sync2_d     = sync1_q;
    armed_d     = armed_q;
    div_cnt_d   = div_cnt_q;
    tcnt_d      = tcnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    baud_d      = baud_q;
    par_d       = par_q;
    stop2_d     = stop2_q;
    len8_d      = len8_q;
    stop_cnt_d  = stop_cnt_q;
    pend_perr_d = pend_perr_q;
    pend_serr_d = pend_serr_q;
    data_out_d  = data_out_q;
    perr_d      = perr_q;
    serr_d      = serr_q;

    // armed = line seen high since the last start; a low line while armed
    // is the 1->0 edge, and also catches an edge that landed in DONE
    if (rxd) armed_d = 1'b1;

    if (state_q == S_IDLE || tick) div_cnt_d = '0;
    else                           div_cnt_d = div_cnt_q + CW'(1);

    if (tick) tcnt_d = tcnt_q + 4'd1;

    unique case (state_q)
      S_IDLE: begin
        tcnt_d = '0;
        if (armed_q && !rxd) begin
          state_d     = S_START;
          armed_d     = 1'b0;
          baud_d      = bus.baud_rate;
          par_d       = bus.parity_type;
          stop2_d     = bus.stop_bits;
          len8_d      = bus.data_length;
          pend_perr_d = 1'b0;
          pend_serr_d = 1'b0;
        end
      end
      S_START: begin
        if (tick && tcnt_q == 4'd7) begin
          tcnt_d    = '0;
          bit_cnt_d = '0;
          state_d   = rxd ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (tick && tcnt_q == 4'd15) begin
          shift_d   = {rxd, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == (len8_q ? 3'd7 : 3'd6)) begin
            stop_cnt_d = 1'b0;
            state_d    = par_en ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (tick && tcnt_q == 4'd15) begin
          // odd wants total XOR 1, even wants 0
          pend_perr_d = (^word ^ rxd) ^ (par_q == 2'b01);
          state_d     = S_STOP;
        end
      end
      S_STOP: begin
        if (tick && tcnt_q == 4'd15) begin
          if (!rxd) pend_serr_d = 1'b1;
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            state_d    = S_DONE;
            data_out_d = word;
            perr_d     = par_en & pend_perr_q;
            serr_d     = pend_serr_q | ~rxd;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        // break: hold off until the line has returned high
        if (serr_q && !rxd) armed_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      armed_q     <= 1'b1;
      div_cnt_q   <= '0;
      tcnt_q      <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      baud_q      <= '0;
      par_q       <= '0;
      stop2_q     <= 1'b0;
      len8_q      <= 1'b0;
      stop_cnt_q  <= 1'b0;
      pend_perr_q <= 1'b0;
      pend_serr_q <= 1'b0;
      data_out_q  <= '0;
      perr_q      <= 1'b0;
      serr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      armed_q     <= armed_d;
      div_cnt_q   <= div_cnt_d;
      tcnt_q      <= tcnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      baud_q      <= baud_d;
      par_q       <= par_d;
      stop2_q     <= stop2_d;
      len8_q      <= len8_d;
      stop_cnt_q  <= stop_cnt_d;
      pend_perr_q <= pend_perr_d;
      pend_serr_q <= pend_serr_d;
      data_out_q  <= data_out_d;
      perr_q      <= perr_d;
      serr_q      <= serr_d;
    end
  end

  assign bus.data_out     = data_out_q;
  assign bus.parity_error = perr_q;
  assign bus.stop_error   = serr_q;
  assign bus.rx_done      = (state_q == S_DONE);
  assign bus.rx_active    = (state_q == S_START) || (state_q == S_DATA) ||
                            (state_q == S_PARITY) || (state_q == S_STOP);

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
  localparam int unsigned CLK_FREQ = 1_536_000;

  logic clock = 1'b0;
  logic rst   = 1'b0;
  always #5 clock = ~clock;

  uart_rx_if bus();
  uart_rx #(.CLK_FREQ(CLK_FREQ)) dut (.clock(clock), .rst(rst), .bus(bus));

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       serr;
  } rec_t;

  typedef struct {
    logic [1:0] baud;
    logic [1:0] ptype;
    logic       stop2;
    logic       len8;
    logic [7:0] data;
    logic       flip;
    logic [1:0] smask;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_serr;
  } vec_t;

  int   errors   = 0;
  int   checks   = 0;
  int   exp_done = 0;
  int   done_cnt = 0;
  int   dbl      = 0;
  int   act_run  = 0;
  int   last_act = 0;
  logic prev_done = 1'b0;
  rec_t recs[$];
  logic line_q[$];

  always @(negedge clock) begin
    if (bus.rx_done === 1'b1) begin
      recs.push_back('{bus.data_out, bus.parity_error, bus.stop_error});
      done_cnt++;
      if (prev_done) dbl++;
    end
    prev_done = (bus.rx_done === 1'b1);
    if (bus.rx_active === 1'b1) act_run++;
    else if (act_run != 0) begin
      last_act = act_run;
      act_run  = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int bit_len(input logic [1:0] b);
    int unsigned rate;
    case (b)
      2'b00:   rate = 2400;
      2'b01:   rate = 4800;
      2'b10:   rate = 9600;
      default: rate = 19200;
    endcase
    return 16 * int'(CLK_FREQ / (16 * rate));
  endfunction

  task automatic set_cfg(input logic [1:0] b, input logic [1:0] p, input logic s2, input logic l8);
    bus.baud_rate   = b;
    bus.parity_type = p;
    bus.stop_bits   = s2;
    bus.data_length = l8;
  endtask

  task automatic make_frame(input logic [7:0] d, input logic len8, input logic [1:0] pt,
                            input logic s2, input logic flip, input logic [1:0] smask);
    logic p;
    int   n;
    n = len8 ? 8 : 7;
    p = 1'b0;
    line_q.delete();
    line_q.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      line_q.push_back(d[i]);
      p ^= d[i];
    end
    if (pt == 2'b01 || pt == 2'b10) begin
      if (pt == 2'b01) p = ~p;
      if (flip) p = ~p;
      line_q.push_back(p);
    end
    line_q.push_back(~smask[0]);
    if (s2) line_q.push_back(~smask[1]);
  endtask

  // Decodes the bit list on the line the way a receiver should see it.
  function automatic rec_t model(input logic len8, input logic [1:0] pt);
    rec_t r;
    int   n, k;
    logic x;
    n = len8 ? 8 : 7;
    r.data = '0;
    x = 1'b0;
    for (int i = 0; i < n; i++) begin
      r.data[i] = line_q[1 + i];
      x ^= line_q[1 + i];
    end
    k = 1 + n;
    r.perr = 1'b0;
    if (pt == 2'b01 || pt == 2'b10) begin
      x ^= line_q[k];
      r.perr = (pt == 2'b01) ? ~x : x;
      k++;
    end
    r.serr = 1'b0;
    for (int j = k; j < line_q.size(); j++) if (!line_q[j]) r.serr = 1'b1;
    return r;
  endfunction

  task automatic send_line(input logic mid_chg);
    logic [1:0] orig;
    int         bl;
    orig = bus.baud_rate;
    bl   = bit_len(orig);
    for (int i = 0; i < line_q.size(); i++) begin
      if (mid_chg && i == 4) bus.baud_rate = ~orig;
      if (mid_chg && i == line_q.size() - 1) bus.baud_rate = orig;
      bus.data_in = line_q[i];
      repeat (bl) @(negedge clock);
    end
  endtask

  task automatic idle_bits(input int n);
    bus.data_in = 1'b1;
    repeat (n * bit_len(bus.baud_rate)) @(negedge clock);
  endtask

  task automatic expect_frame(input string tag, input rec_t e);
    rec_t r;
    int   k;
    exp_done++;
    k = 0;
    while (done_cnt < exp_done && k < 4000) begin
      @(negedge clock);
      k++;
    end
    check({tag, ".arrived"}, 32'(done_cnt >= exp_done), 32'd1);
    if (recs.size() > 0) begin
      r = recs.pop_front();
      check({tag, ".data"}, 32'(r.data), 32'(e.data));
      check({tag, ".perr"}, 32'(r.perr), 32'(e.perr));
      check({tag, ".serr"}, 32'(r.serr), 32'(e.serr));
    end
  endtask

  vec_t tbl[7];

  initial begin
    rec_t e;
    int   c0;
    logic [7:0] d0;
    logic [1:0] b, p;
    logic       s2, l8, fl;
    logic [1:0] sm;

    tbl[0] = '{2'b10, 2'b00, 1'b0, 1'b1, 8'hA5, 1'b0, 2'b00, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{2'b10, 2'b10, 1'b1, 1'b0, 8'h7F, 1'b0, 2'b00, 8'h7F, 1'b0, 1'b0};
    tbl[2] = '{2'b10, 2'b10, 1'b1, 1'b0, 8'h7F, 1'b1, 2'b00, 8'h7F, 1'b1, 1'b0};
    tbl[3] = '{2'b11, 2'b01, 1'b0, 1'b1, 8'h3C, 1'b0, 2'b00, 8'h3C, 1'b0, 1'b0};
    tbl[4] = '{2'b01, 2'b00, 1'b0, 1'b0, 8'hFF, 1'b0, 2'b00, 8'h7F, 1'b0, 1'b0};
    tbl[5] = '{2'b10, 2'b10, 1'b0, 1'b1, 8'h81, 1'b0, 2'b01, 8'h81, 1'b0, 1'b1};
    tbl[6] = '{2'b10, 2'b01, 1'b1, 1'b1, 8'hC3, 1'b0, 2'b10, 8'hC3, 1'b0, 1'b1};

    // reset values
    bus.data_in = 1'b1;
    set_cfg(2'b10, 2'b00, 1'b0, 1'b1);
    rst = 1'b0;
    repeat (4) @(negedge clock);
    check("rst.data_out",  32'(bus.data_out),     32'd0);
    check("rst.rx_done",   32'(bus.rx_done),      32'd0);
    check("rst.rx_active", 32'(bus.rx_active),    32'd0);
    check("rst.perr",      32'(bus.parity_error), 32'd0);
    check("rst.serr",      32'(bus.stop_error),   32'd0);
    rst = 1'b1;
    repeat (4) @(negedge clock);

    // table-driven frames
    for (int v = 0; v < 7; v++) begin
      set_cfg(tbl[v].baud, tbl[v].ptype, tbl[v].stop2, tbl[v].len8);
      make_frame(tbl[v].data, tbl[v].len8, tbl[v].ptype, tbl[v].stop2, tbl[v].flip, tbl[v].smask);
      send_line(1'b0);
      idle_bits(2);
      e = '{tbl[v].exp_data, tbl[v].exp_perr, tbl[v].exp_serr};
      expect_frame($sformatf("vec%0d", v), e);
      if (v == 0) check("vec0.active_len_ok", 32'(last_act >= 1500 && last_act <= 1540), 32'd1);
    end

    // randomized frames against the line decoder model
    for (int n = 0; n < 16; n++) begin
      b  = 2'($urandom_range(2, 3));
      p  = 2'($urandom_range(0, 3));
      s2 = 1'($urandom_range(0, 1));
      l8 = 1'($urandom_range(0, 1));
      fl = ($urandom_range(0, 3) == 0);
      sm = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      set_cfg(b, p, s2, l8);
      make_frame(8'($urandom), l8, p, s2, fl, sm);
      e = model(l8, p);
      send_line(1'b0);
      idle_bits(2);
      expect_frame($sformatf("rnd%0d", n), e);
    end

    // glitch rejection
    set_cfg(2'b10, 2'b00, 1'b0, 1'b1);
    c0 = done_cnt;
    d0 = bus.data_out;
    bus.data_in = 1'b0;
    repeat (40) @(negedge clock);
    bus.data_in = 1'b1;
    repeat (200) @(negedge clock);
    check("glitch.no_done",   32'(done_cnt), 32'(c0));
    check("glitch.active",    32'(bus.rx_active), 32'd0);
    check("glitch.data_hold", 32'(bus.data_out), 32'(d0));
    check("glitch.start_seen", 32'(last_act >= 75 && last_act <= 85), 32'd1);

    // framing error followed by a held-low break
    set_cfg(2'b10, 2'b01, 1'b0, 1'b1);
    c0 = done_cnt;
    make_frame(8'h55, 1'b1, 2'b01, 1'b0, 1'b0, 2'b01);
    send_line(1'b0);
    bus.data_in = 1'b0;
    repeat (3 * 160) @(negedge clock);
    check("break.one_done_low", 32'(done_cnt - c0), 32'd1);
    check("break.idle_low",     32'(bus.rx_active), 32'd0);
    idle_bits(2);
    check("break.one_done", 32'(done_cnt - c0), 32'd1);
    e = '{8'h55, 1'b0, 1'b1};
    expect_frame("break", e);

    // back-to-back at 2400 with a baud change inside the first frame
    set_cfg(2'b00, 2'b00, 1'b0, 1'b1);
    make_frame(8'h00, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00);
    send_line(1'b1);
    make_frame(8'hFF, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00);
    send_line(1'b0);
    idle_bits(2);
    e = '{8'h00, 1'b0, 1'b0};
    expect_frame("b2b0", e);
    e = '{8'hFF, 1'b0, 1'b0};
    expect_frame("b2b1", e);

    // reset in the middle of data bit 3
    set_cfg(2'b10, 2'b00, 1'b0, 1'b1);
    make_frame(8'h3C, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00);
    for (int i = 0; i < 4; i++) begin
      bus.data_in = line_q[i];
      repeat (160) @(negedge clock);
    end
    bus.data_in = line_q[4];
    repeat (80) @(negedge clock);
    check("mid.active_before", 32'(bus.rx_active), 32'd1);
    rst = 1'b0;
    @(negedge clock);
    check("mid_rst.data_out",  32'(bus.data_out),     32'd0);
    check("mid_rst.rx_done",   32'(bus.rx_done),      32'd0);
    check("mid_rst.rx_active", 32'(bus.rx_active),    32'd0);
    check("mid_rst.perr",      32'(bus.parity_error), 32'd0);
    check("mid_rst.serr",      32'(bus.stop_error),   32'd0);
    rst = 1'b1;
    idle_bits(2);
    check("mid_rst.no_spurious", 32'(done_cnt), 32'(exp_done));
    send_line(1'b0);
    idle_bits(2);
    e = '{8'h3C, 1'b0, 1'b0};
    expect_frame("after_rst", e);

    check("single_cycle_done", 32'(dbl), 32'd0);
    check("done_total", 32'(done_cnt), 32'(exp_done));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
